// File: rtl/full_add_4bit_if.sv
// full_add_4bit_if: operand and registered-result bundle for the 4-bit adder
interface full_add_4bit_if;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic       C_in;
  logic [3:0] S_out;
  logic       C_out;
  modport master (output A_in, B_in, C_in, input S_out, C_out);
  modport slave (input A_in, B_in, C_in, output S_out, C_out);
endinterface

// File: rtl/full_add_4bit.sv
// full_add_4bit: four rippled full-adder slices feeding registered sum and carry-out
module full_add_4bit (
  input logic clk,
  input logic rst,
  full_add_4bit_if.slave bus
);
  logic [4:0] c;
  logic [3:0] s;
  logic [3:0] s_d, s_q;
  logic       c_d, c_q;
  assign c[0] = bus.C_in;
  for (genvar i = 0; i < 4; i++) begin : g_slice
    assign s[i]   = bus.A_in[i] ^ bus.B_in[i] ^ c[i];
    assign c[i+1] = (bus.A_in[i] & bus.B_in[i]) | (c[i] & (bus.A_in[i] ^ bus.B_in[i]));
  end
  always_comb begin
    s_d = s;
    c_d = c[4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end
  assign bus.S_out = s_q;
  assign bus.C_out = c_q;
endmodule

// File: tb/tb_full_add_4bit.sv
// tb_full_add_4bit: directed and exhaustive checks of the registered 4-bit adder
module tb_full_add_4bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  full_add_4bit_if bus ();
  full_add_4bit dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.C_out, bus.S_out};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    bus.A_in = a;
    bus.B_in = b;
    bus.C_in = ci;
  endtask
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci);
    drive(a, b, ci);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [4:0] exp;
    drive(4'd15, 4'd15, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 5'd0);
    rst = 1'b0;
    step(4'd15, 4'd15, 1'b1);
    check("first_after_reset", 5'd31);
    step(4'd0, 4'd0, 1'b0);
    check("zero", 5'd0);
    step(4'd4, 4'd3, 1'b0);
    check("4+3", 5'd7);
    step(4'd2, 4'd3, 1'b1);
    check("2+3+1", 5'd6);
    step(4'd7, 4'd3, 1'b1);
    check("7+3+1", 5'd11);
    step(4'd15, 4'd0, 1'b1);
    check("ripple_15+0+1", 5'd16);
    step(4'd8, 4'd8, 1'b0);
    check("8+8", 5'd16);
    step(4'd1, 4'd14, 1'b0);
    check("1+14", 5'd15);
    step(4'd9, 4'd9, 1'b0);
    check("9+9", 5'd18);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset", 5'd0);
    rst = 1'b0;
    step(4'd5, 4'd6, 1'b1);
    check("after_mid_reset", 5'd12);
    step(4'd3, 4'd4, 1'b0);
    check("stable_base", 5'd7);
    drive(4'd15, 4'd15, 1'b1);
    #2;
    check("stable_toggle1", 5'd7);
    drive(4'd1, 4'd1, 1'b0);
    #5;
    check("stable_toggle2", 5'd7);
    @(posedge clk);
    #1;
    check("stable_update", 5'd2);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step(v[3:0], v[7:4], v[8]);
      exp = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      check("exhaustive", exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
